// File: rtl/jtcop_obj_pkg.sv
// Shared definitions for the DECO-era sprite line drawer.
//   - engine state encoding
//   - fixed field widths of a sprite draw command
//   - bit positions of the four pixel planes inside a 32-bit tile row half,
//     for normal and horizontally flipped pixel order
//   - obj_pixel(): extracts the current pixel from a tile row half
package jtcop_obj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2
    } obj_state_e;

    // Command field widths that do not depend on the top parameters
    localparam int XPOS_W = 9;
    localparam int VSUB_W = 4;
    localparam int NT_W   = 3;
    localparam int MLOG_W = 2;
    localparam int ROW_W  = 32;

    // Plane bit positions, pixel bit 3 first. Normal order draws from the
    // top of each byte and shifts left; flipped order draws from the bottom
    // of each byte and shifts right.
    localparam int NF_B3 = 15;
    localparam int NF_B2 = 31;
    localparam int NF_B1 = 7;
    localparam int NF_B0 = 23;
    localparam int HF_B3 = 8;
    localparam int HF_B2 = 24;
    localparam int HF_B1 = 0;
    localparam int HF_B0 = 16;

    function automatic logic [3:0] obj_pixel(input logic [ROW_W-1:0] d,
                                             input logic              hflip);
        if (hflip) begin
            return {d[HF_B3], d[HF_B2], d[HF_B1], d[HF_B0]};
        end
        return {d[NF_B3], d[NF_B2], d[NF_B1], d[NF_B0]};
    endfunction

endpackage

// File: rtl/jtcop_obj_cmdfifo.sv
// Synchronous command FIFO for the sprite line drawer.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush_i       synchronous empty, has priority over push and pop
//   push_i/pop_i  write / read strobes (rdata_o is valid whenever !empty_o)
//   wdata_i       entry to store
//   rdata_o       oldest entry (first-word fall-through)
//   full_o        all 2**AW entries used
//   empty_o       no entry stored
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle, so occupancy stays the same.
module jtcop_obj_cmdfifo #(
    parameter int AW = 2,
    parameter int DW = 8
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after being written
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/jtcop_obj_tiledraw.sv
// Sprite line drawer: queues pre-parsed draw commands, fetches 4bpp tile row
// halves (8 pixels, 32 bits) from the object ROM and writes one pixel per
// cycle into an external line buffer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hs              line start: one-cycle flush of FIFO, engine and budget
//   flip            screen flip, mirrors line buffer addresses
//   cmd_*           draw command; cmd_valid/cmd_ready handshake below
//   rom_cs/addr     ROM request, address {code, half_sel, vsub, 1'b0}
//   rom_data/ok     ROM row half and its valid flag
//   buf_addr/data/we  registered line buffer write port, data = {pal, pixel}
//   busy            engine active or commands pending
//   overrun         tile budget for this line used up
// Handshake: a command is taken on every rising clock edge where cmd_valid
// and cmd_ready are both high and hs is low. cmd_ready is high whenever the
// FIFO has a free entry and does not depend on cmd_valid.
module jtcop_obj_tiledraw
    import jtcop_obj_pkg::*;
#(
    parameter int         CW       = 12,
    parameter int         PW       = 4,
    parameter int         FIFO_AW  = 2,
    parameter int         MAXTILES = 48,
    parameter logic [8:0] XMAX     = 9'd256,
    parameter logic [8:0] FLIPOFS  = 9'h100,
    parameter logic [3:0] ALPHA    = 4'd0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              flip,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CW-1:0]     cmd_code,
    input  logic [8:0]        cmd_xpos,
    input  logic [3:0]        cmd_vsub,
    input  logic              cmd_hflip,
    input  logic              cmd_vflip,
    input  logic [PW-1:0]     cmd_pal,
    input  logic [2:0]        cmd_ntiles,
    input  logic [1:0]        cmd_mlog,
    output logic              rom_cs,
    output logic [CW+5:0]     rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              rom_ok,
    output logic [8:0]        buf_addr,
    output logic [PW+3:0]     buf_data,
    output logic              buf_we,
    output logic              busy,
    output logic              overrun
);
    localparam int CMD_W  = CW + XPOS_W + VSUB_W + 2 + PW + NT_W + MLOG_W;
    localparam int TILE_W = $clog2(MAXTILES + 1);
    localparam logic [TILE_W-1:0] TILE_MAX = TILE_W'(MAXTILES);

    // Command FIFO
    logic [CMD_W-1:0]  fifo_wdata, fifo_rdata;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0]     f_code;
    logic [XPOS_W-1:0] f_xpos;
    logic [VSUB_W-1:0] f_vsub;
    logic              f_hflip, f_vflip;
    logic [PW-1:0]     f_pal;
    logic [NT_W-1:0]   f_ntiles;
    logic [MLOG_W-1:0] f_mlog;

    assign fifo_wdata = {cmd_code, cmd_xpos, cmd_vsub, cmd_hflip, cmd_vflip,
                         cmd_pal, cmd_ntiles, cmd_mlog};
    assign {f_code, f_xpos, f_vsub, f_hflip, f_vflip,
            f_pal, f_ntiles, f_mlog} = fifo_rdata;
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;

    jtcop_obj_cmdfifo #(.AW(FIFO_AW), .DW(CMD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (hs),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Engine registers
    obj_state_e        state_q, state_d;
    logic [CW+5:0]     rom_addr_q, rom_addr_d;
    logic              rom_cs_q, rom_cs_d;
    logic              settle_q, settle_d;
    logic              half_q, half_d;
    logic              hflip_q, hflip_d;
    logic [PW-1:0]     pal_q, pal_d;
    logic [NT_W-1:0]   ntiles_q, ntiles_d;
    logic [MLOG_W-1:0] mlog_q, mlog_d;
    logic [ROW_W-1:0]  data_q, data_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [8:0]        x_q, x_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic              overrun_q, overrun_d;
    logic              buf_we_q, buf_we_d;
    logic [8:0]        buf_addr_q, buf_addr_d;
    logic [PW+3:0]     buf_data_q, buf_data_d;

    logic [3:0]        pix;
    logic [TILE_W-1:0] tiles_inc;

    assign pix       = obj_pixel(data_q, hflip_q);
    assign tiles_inc = tiles_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rom_cs_d   = rom_cs_q;
        settle_d   = settle_q;
        half_d     = half_q;
        hflip_d    = hflip_q;
        pal_d      = pal_q;
        ntiles_d   = ntiles_q;
        mlog_d     = mlog_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        tiles_d    = tiles_q;
        overrun_d  = overrun_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Past the budget the command is popped and dropped
                    if (!overrun_q) begin
                        hflip_d    = f_hflip;
                        pal_d      = f_pal;
                        ntiles_d   = f_ntiles;
                        mlog_d     = f_mlog;
                        x_d        = f_xpos;
                        half_d     = 1'b0;
                        settle_d   = 1'b0;
                        rom_cs_d   = 1'b1;
                        rom_addr_d = {f_code, ~f_hflip,
                                      f_vsub ^ {VSUB_W{f_vflip}}, 1'b0};
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // rom_ok must be seen on two consecutive cycles so that a
                // stale ok from the previous address is never taken
                settle_d = rom_ok;
                if (settle_q && rom_ok) begin
                    data_d   = rom_data;
                    rom_cs_d = 1'b0;
                    cnt_d    = 3'd7;
                    state_d  = ST_DRAW;
                end
            end
            ST_DRAW: begin
                buf_data_d = {pal_q, pix};
                buf_addr_d = flip ? FLIPOFS - x_q : x_q;
                buf_we_d   = (pix != ALPHA) && (x_q < XMAX);
                x_d        = x_q + 9'd1;
                data_d     = hflip_q ? data_q >> 1 : data_q << 1;
                cnt_d      = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    if (!half_q) begin
                        rom_addr_d[5] = ~rom_addr_q[5];
                        half_d        = 1'b1;
                        rom_cs_d      = 1'b1;
                        settle_d      = 1'b0;
                        state_d       = ST_FETCH;
                    end else begin
                        tiles_d = tiles_inc;
                        if (tiles_inc == TILE_MAX) begin
                            overrun_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else if (ntiles_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            rom_addr_d[CW+5:6] = rom_addr_q[CW+5:6] + (CW'(1) << mlog_q);
                            rom_addr_d[5]      = ~hflip_q;
                            ntiles_d           = ntiles_q - 1'b1;
                            half_d             = 1'b0;
                            rom_cs_d           = 1'b1;
                            settle_d           = 1'b0;
                            state_d            = ST_FETCH;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // hs acts as a reset for everything in the engine
    always_ff @(posedge clk) begin
        if (rst || hs) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            settle_q   <= 1'b0;
            half_q     <= 1'b0;
            hflip_q    <= 1'b0;
            pal_q      <= '0;
            ntiles_q   <= '0;
            mlog_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            tiles_q    <= '0;
            overrun_q  <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= rom_cs_d;
            settle_q   <= settle_d;
            half_q     <= half_d;
            hflip_q    <= hflip_d;
            pal_q      <= pal_d;
            ntiles_q   <= ntiles_d;
            mlog_q     <= mlog_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            tiles_q    <= tiles_d;
            overrun_q  <= overrun_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_jtcop_obj_tiledraw.sv
// Directed bench for jtcop_obj_tiledraw. The ROM model returns one of two
// fixed row halves chosen by rom_addr[5]; they were picked so that the
// unflipped tile draws pixels 0..15 and the flipped tile draws 15..0.
module tb_jtcop_obj_tiledraw;
    localparam int CW = 12;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst, hs, flip, cmd_valid, cmd_ready;
    logic [CW-1:0] cmd_code;
    logic [8:0]    cmd_xpos;
    logic [3:0]    cmd_vsub;
    logic          cmd_hflip, cmd_vflip;
    logic [PW-1:0] cmd_pal;
    logic [2:0]    cmd_ntiles;
    logic [1:0]    cmd_mlog;
    logic          rom_cs, rom_ok, rom_ok_en;
    logic [CW+5:0] rom_addr;
    logic [31:0]   rom_data;
    logic [8:0]    buf_addr;
    logic [PW+3:0] buf_data;
    logic          buf_we, busy, overrun;

    // Clock / reset
    always #5 clk = ~clk;

    jtcop_obj_tiledraw dut (
        .clk        (clk),
        .rst        (rst),
        .hs         (hs),
        .flip       (flip),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_xpos   (cmd_xpos),
        .cmd_vsub   (cmd_vsub),
        .cmd_hflip  (cmd_hflip),
        .cmd_vflip  (cmd_vflip),
        .cmd_pal    (cmd_pal),
        .cmd_ntiles (cmd_ntiles),
        .cmd_mlog   (cmd_mlog),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .buf_we     (buf_we),
        .busy       (busy),
        .overrun    (overrun)
    );

    assign rom_data = rom_addr[5] ? 32'h0F550033 : 32'h0F55FF33;
    assign rom_ok   = rom_ok_en;

    // Scoreboard
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] exp_q[$];
    logic [16:0] act_q[$];
    logic [17:0] exp_a_q[$];
    logic [17:0] act_a_q[$];
    logic        cs_prev = 1'b0;
    logic [17:0] addr_prev = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (buf_we) act_q.push_back({buf_addr, buf_data});
            if (rom_cs && (!cs_prev || rom_addr != addr_prev)) act_a_q.push_back(rom_addr);
        end
        cs_prev   = rom_cs;
        addr_prev = rom_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [CW-1:0] code, input logic [8:0] xpos,
                            input logic [3:0] vsub, input logic hf, input logic vf,
                            input logic [PW-1:0] pal, input logic [2:0] nt,
                            input logic [1:0] mlog);
        int w;
        cmd_code = code; cmd_xpos = xpos; cmd_vsub = vsub; cmd_hflip = hf;
        cmd_vflip = vf; cmd_pal = pal; cmd_ntiles = nt; cmd_mlog = mlog;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 3000) begin
            tick();
            w++;
        end
        if (!cmd_ready) check("push_timeout", 32'd0, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 3000) begin
            tick();
            w++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        repeat (3) tick();
    endtask

    task automatic pulse_hs();
        hs = 1'b1;
        tick();
        hs = 1'b0;
    endtask

    // Expected writes for npix consecutive pixels of the test pattern
    task automatic add_exp(input int xpos, input logic [PW-1:0] pal,
                           input logic hf, input logic fl, input int npix);
        for (int k = 0; k < npix; k++) begin
            logic [3:0] p;
            logic [8:0] x;
            p = hf ? 4'(15 - (k % 16)) : 4'(k % 16);
            x = 9'(xpos + k);
            if (p != 4'd0 && x < 9'd256)
                exp_q.push_back({fl ? 9'(9'h100 - x) : x, pal, p});
        end
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_nwr"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wr%0d", tag, i), act_q[i], exp_q[i]);
        check({tag, "_nrom"}, act_a_q.size(), exp_a_q.size());
        n = (act_a_q.size() < exp_a_q.size()) ? act_a_q.size() : exp_a_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_rom%0d", tag, i), act_a_q[i], exp_a_q[i]);
        exp_q.delete(); act_q.delete(); exp_a_q.delete(); act_a_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; hs = 1'b0; flip = 1'b0; cmd_valid = 1'b0; rom_ok_en = 1'b1;
        cmd_code = '0; cmd_xpos = '0; cmd_vsub = '0; cmd_hflip = 1'b0;
        cmd_vflip = 1'b0; cmd_pal = '0; cmd_ntiles = '0; cmd_mlog = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_rom_cs",   rom_cs,   0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_buf_we",   buf_we,   0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_buf_data", buf_data, 0);
        check("rst_overrun",  overrun,  0);
        check("rst_busy",     busy,     0);
        check("rst_ready",    cmd_ready, 1);

        // Single tile, no flips
        push_cmd(12'h123, 9'd16, 4'd5, 1'b0, 1'b0, 4'hA, 3'd0, 2'd0);
        add_exp(16, 4'hA, 1'b0, 1'b0, 16);
        exp_a_q.push_back(18'h048EA); exp_a_q.push_back(18'h048CA);
        wait_idle();
        compare("t1");

        // hflip + vflip, also first-write latency
        push_cmd(12'h055, 9'd100, 4'd5, 1'b1, 1'b1, 4'h3, 3'd0, 2'd0);
        n = 0;
        while (!buf_we && n < 50) begin
            tick();
            n++;
        end
        check("t2_latency", n, 4);
        add_exp(100, 4'h3, 1'b1, 1'b0, 16);
        exp_a_q.push_back(18'h01554); exp_a_q.push_back(18'h01574);
        wait_idle();
        compare("t2");

        // Three tiles, code step 4
        push_cmd(12'h100, 9'd200, 4'd0, 1'b0, 1'b0, 4'h5, 3'd2, 2'd2);
        add_exp(200, 4'h5, 1'b0, 1'b0, 48);
        exp_a_q.push_back(18'h04020); exp_a_q.push_back(18'h04000);
        exp_a_q.push_back(18'h04120); exp_a_q.push_back(18'h04100);
        exp_a_q.push_back(18'h04220); exp_a_q.push_back(18'h04200);
        wait_idle();
        compare("t3");

        // Screen flip: addresses count down from 0x100
        flip = 1'b1;
        push_cmd(12'h010, 9'd0, 4'd0, 1'b1, 1'b0, 4'h6, 3'd0, 2'd0);
        add_exp(0, 4'h6, 1'b1, 1'b1, 16);
        exp_a_q.push_back(18'h00400); exp_a_q.push_back(18'h00420);
        wait_idle();
        flip = 1'b0;
        compare("t4a");

        // Right clip: x >= 256 not written
        push_cmd(12'h020, 9'd250, 4'd0, 1'b0, 1'b0, 4'h7, 3'd0, 2'd0);
        add_exp(250, 4'h7, 1'b0, 1'b0, 16);
        exp_a_q.push_back(18'h00820); exp_a_q.push_back(18'h00800);
        wait_idle();
        compare("t4b");

        // Tile budget
        pulse_hs();
        act_q.delete(); act_a_q.delete();
        for (int i = 0; i < 47; i++)
            push_cmd(12'h000, 9'd0, 4'd0, 1'b0, 1'b0, 4'h0, 3'd0, 2'd0);
        wait_idle();
        check("bud47_overrun", overrun, 0);
        check("bud47_nwr", act_q.size(), 47 * 15);
        push_cmd(12'h000, 9'd0, 4'd0, 1'b0, 1'b0, 4'h0, 3'd0, 2'd0);
        wait_idle();
        check("bud48_overrun", overrun, 1);
        check("bud48_nwr", act_q.size(), 48 * 15);
        push_cmd(12'h000, 9'd0, 4'd0, 1'b0, 1'b0, 4'h0, 3'd0, 2'd0);
        wait_idle();
        check("bud49_overrun", overrun, 1);
        check("bud49_nwr", act_q.size(), 48 * 15);
        check("bud49_nrom", act_a_q.size(), 96);
        check("bud49_busy", busy, 0);
        pulse_hs();
        check("bud_hs_overrun", overrun, 0);
        act_q.delete(); act_a_q.delete();

        // hs in FETCH with three commands queued, and a same-cycle push
        rom_ok_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push_cmd(12'h300 + 12'(i), 9'd0, 4'd0, 1'b0, 1'b0, 4'h1, 3'd0, 2'd0);
        check("fl_pre_cs",    rom_cs,    1);
        check("fl_pre_busy",  busy,      1);
        check("fl_pre_ready", cmd_ready, 1);
        hs = 1'b1;
        cmd_valid = 1'b1;
        tick();
        hs = 1'b0;
        cmd_valid = 1'b0;
        check("fl_cs",    rom_cs,    0);
        check("fl_busy",  busy,      0);
        check("fl_ready", cmd_ready, 1);
        check("fl_we",    buf_we,    0);
        act_q.delete(); act_a_q.delete();
        rom_ok_en = 1'b1;
        repeat (30) tick();
        check("fl_post_nrom", act_a_q.size(), 0);
        check("fl_post_nwr",  act_q.size(),   0);
        check("fl_post_busy", busy, 0);

        // Full FIFO drops cmd_ready, hs clears it
        rom_ok_en = 1'b0;
        for (int i = 0; i < 5; i++)
            push_cmd(12'h400 + 12'(i), 9'd0, 4'd0, 1'b0, 1'b0, 4'h1, 3'd0, 2'd0);
        check("full_ready", cmd_ready, 0);
        pulse_hs();
        check("full_hs_ready", cmd_ready, 1);
        check("full_hs_busy",  busy,      0);
        rom_ok_en = 1'b1;
        act_q.delete(); act_a_q.delete();

        // Normal operation after the flushes
        push_cmd(12'h123, 9'd16, 4'd5, 1'b0, 1'b0, 4'hA, 3'd0, 2'd0);
        add_exp(16, 4'hA, 1'b0, 1'b0, 16);
        exp_a_q.push_back(18'h048EA); exp_a_q.push_back(18'h048CA);
        wait_idle();
        compare("t7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
